pixel_plot_writer: RTL

- Downstream stage of the line-drawing engine in the hexagon renderer.
- Consumes one plot request at a time: signed 32-bit coordinates plus a colour.
- Clips the request to the screen, converts (x, y) to a linear framebuffer address, and issues one write on the framebuffer request/acknowledge port.
- Returns a single-cycle vga_done pulse so the line engine can advance to the next pixel.

---
 rtl/pixel_plot_writer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/pixel_plot_writer.sv
// ============================================================================
// pixel_plot_writer
//
// Final stage of the line-drawing engine. It takes one plot request at a
// time, clips it against the visible screen, turns (x, y) into a linear
// framebuffer address and issues a single req/ack write. A one-cycle
// vga_done pulse tells the line engine that the request has finished,
// whether it was written or clipped.
//
// Optional statistics counters are compiled in when PIXEL_PLOT_STATS_EN is
// defined. Without it, pix_written/pix_clipped read as 0, clear_stats is
// ignored and the port list stays the same.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   vga_plot     plot request level from the line engine
//   vga_x/vga_y  signed 32-bit pixel coordinates, sampled in IDLE
//   color        pixel colour, sampled together with the coordinates
//   vga_done     one-cycle pulse when the request is finished
//   fb_req       framebuffer write request
//   fb_addr      write address, stable while fb_req=1
//   fb_data      write data, stable while fb_req=1
//   fb_ack       framebuffer accepted the write (used only in WRITE)
//   busy         high in every state except IDLE
//   clear_stats  zeroes the statistics counters
//   pix_written  saturating count of pixels written
//   pix_clipped  saturating count of pixels clipped
// ============================================================================
module pixel_plot_writer #(
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter int ADDR_W   = 17,
    parameter int COLOR_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vga_plot,
    input  logic [31:0]        vga_x,
    input  logic [31:0]        vga_y,
    input  logic [COLOR_W-1:0] color,
    output logic               vga_done,
    output logic               fb_req,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_data,
    input  logic               fb_ack,
    output logic               busy,
    input  logic               clear_stats,
    output logic [15:0]        pix_written,
    output logic [15:0]        pix_clipped
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_WRITE,
        S_DONE,
        S_WAIT_LOW
    } state_t;

    state_t              state_q;
    logic signed [31:0]  x_q;
    logic signed [31:0]  y_q;
    logic [COLOR_W-1:0]  color_q;
    logic                vga_done_q;
    logic                fb_req_q;
    logic [ADDR_W-1:0]   fb_addr_q;
    logic [COLOR_W-1:0]  fb_data_q;

    // Clip test on the latched coordinates. Signed compares mean a huge
    // positive value such as 32'h7FFFFFFF is clipped rather than wrapping.
    logic              clip_d;
    logic [ADDR_W-1:0] addr_d;

    assign clip_d = (x_q < 0) || (x_q >= SCREEN_W) ||
                    (y_q < 0) || (y_q >= SCREEN_H);

    // Only used when clip_d=0, so the 32-bit product never overflows and the
    // truncation to ADDR_W is lossless for in-bounds pixels.
    assign addr_d = ADDR_W'(y_q * SCREEN_W + x_q);

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    // NOTE: sequential state is assigned with <= so every register samples the
    // pre-edge values; blocking assignments here would create ordering races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            color_q    <= '0;
            vga_done_q <= 1'b0;
            fb_req_q   <= 1'b0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
        end else begin
            vga_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (vga_plot) begin
                        x_q     <= vga_x;
                        y_q     <= vga_y;
                        color_q <= color;
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (clip_d) begin
                        vga_done_q <= 1'b1;
                        state_q    <= S_DONE;
                    end else begin
                        fb_addr_q <= addr_d;
                        fb_data_q <= color_q;
                        fb_req_q  <= 1'b1;
                        state_q   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // No timeout: a stalled framebuffer holds us here.
                    if (fb_ack) begin
                        fb_req_q   <= 1'b0;
                        vga_done_q <= 1'b1;
                        state_q    <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_WAIT_LOW;
                end
                S_WAIT_LOW: begin
                    // The line engine keeps plot high across its own states;
                    // waiting for it to drop guarantees one write per request.
                    if (!vga_plot) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    fb_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign vga_done = vga_done_q;
    assign fb_req   = fb_req_q;
    assign fb_addr  = fb_addr_q;
    assign fb_data  = fb_data_q;
    assign busy     = (state_q != S_IDLE);

    // ------------------------------------------------------------------------
    // Optional statistics
    // ------------------------------------------------------------------------
`ifdef PIXEL_PLOT_STATS_EN
    logic [15:0] pix_written_q;
    logic [15:0] pix_clipped_q;
    logic        written_inc;
    logic        clipped_inc;

    assign written_inc = (state_q == S_WRITE) && fb_ack;
    assign clipped_inc = (state_q == S_CALC) && clip_d;

    // clear_stats is checked before the increments so it wins a collision.
    always_ff @(posedge clk) begin
        if (rst || clear_stats) begin
            pix_written_q <= '0;
            pix_clipped_q <= '0;
        end else begin
            if (written_inc && (pix_written_q != 16'hFFFF)) begin
                pix_written_q <= pix_written_q + 16'd1;
            end
            if (clipped_inc && (pix_clipped_q != 16'hFFFF)) begin
                pix_clipped_q <= pix_clipped_q + 16'd1;
            end
        end
    end

    assign pix_written = pix_written_q;
    assign pix_clipped = pix_clipped_q;
`else
    logic unused_clear_stats;

    assign unused_clear_stats = clear_stats;
    assign pix_written        = '0;
    assign pix_clipped        = '0;
`endif

endmodule
